// File: rtl/delivery_sequencer.sv
// Bowling-end delivery producer for the cricket scorer: LFSR-driven outcomes offered over valid/ready,
// with per-innings ball/over/wicket tracking and innings 1 -> break -> innings 2 -> done sequencing.
module delivery_sequencer #(
  parameter int unsigned MAX_BALLS   = 120,
  parameter int unsigned MAX_WICKETS = 10,
  parameter int unsigned GAP_CYCLES  = 4,
  parameter logic [15:0] DEF_SEED    = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        play,
  input  logic        seed_ld,
  input  logic [15:0] seed,
  input  logic        game_over,
  input  logic        del_ready,
  output logic        del_valid,
  output logic [2:0]  del_runs,
  output logic        del_wicket,
  output logic        del_extra,
  output logic        team,
  output logic [6:0]  legal_balls,
  output logic [4:0]  over_count,
  output logic [2:0]  ball_in_over,
  output logic [3:0]  wickets,
  output logic        innings_over,
  output logic        match_done
);

  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_BOWL  = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_END   = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]    state, state_n;
  logic [15:0]   lfsr;
  logic [GW-1:0] gap_cnt;
  logic          xfer, inn_end;
  logic [6:0]    legal_n;
  logic [3:0]    wickets_n;
  logic [2:0]    dec_runs;
  logic          dec_wicket, dec_extra;

  // Outcome table applied to the low LFSR nibble when a delivery is offered.
  always_comb begin
    dec_runs   = 3'd0;
    dec_wicket = 1'b0;
    dec_extra  = 1'b0;
    case (lfsr[3:0])
      4'd4, 4'd5, 4'd6, 4'd7: dec_runs = 3'd1;
      4'd8:                   dec_runs = 3'd2;
      4'd9:                   dec_runs = 3'd3;
      4'd10, 4'd11:           dec_runs = 3'd4;
      4'd12:                  dec_runs = 3'd6;
      4'd13:                  dec_wicket = 1'b1;
      4'd14, 4'd15: begin
        dec_runs  = 3'd1;
        dec_extra = 1'b1;
      end
      default: ;
    endcase
  end

  // Next-state logic; innings end is judged on the counters as they will be after this transfer.
  always_comb begin
    xfer      = (state == S_BOWL) && del_valid && del_ready;
    legal_n   = legal_balls + 7'(xfer && !del_extra);
    wickets_n = wickets + 4'(xfer && del_wicket);
    inn_end   = (legal_n == 7'(MAX_BALLS)) || (wickets_n == 4'(MAX_WICKETS));
    state_n   = state;
    case (state)
      S_IDLE:  if (play) state_n = S_BOWL;
      S_BOWL:  if (xfer) state_n = inn_end ? S_END : S_GAP;
      S_GAP:   if (gap_cnt == '0 && play) state_n = S_BOWL;
      S_END:   state_n = team ? S_DONE : S_BREAK;
      S_BREAK: if (play) state_n = S_BOWL;
      S_DONE:  state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase
    if (game_over && state != S_IDLE) state_n = S_DONE;
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr         <= DEF_SEED;
      gap_cnt      <= '0;
      del_valid    <= 1'b0;
      del_runs     <= 3'd0;
      del_wicket   <= 1'b0;
      del_extra    <= 1'b0;
      team         <= 1'b0;
      legal_balls  <= 7'd0;
      over_count   <= 5'd0;
      ball_in_over <= 3'd0;
      wickets      <= 4'd0;
      innings_over <= 1'b0;
      match_done   <= 1'b0;
    end else begin
      del_valid    <= (state_n == S_BOWL);
      innings_over <= (state_n == S_END);
      match_done   <= (state_n == S_DONE);

      if (state != S_BOWL && state_n == S_BOWL) begin
        del_runs   <= dec_runs;
        del_wicket <= dec_wicket;
        del_extra  <= dec_extra;
      end

      if (state == S_BREAK && state_n == S_BOWL) begin
        team         <= 1'b1;
        legal_balls  <= 7'd0;
        over_count   <= 5'd0;
        ball_in_over <= 3'd0;
        wickets      <= 4'd0;
      end

      if (xfer) begin
        lfsr        <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        legal_balls <= legal_n;
        wickets     <= wickets_n;
        if (!del_extra) begin
          if (ball_in_over == 3'd5) begin
            ball_in_over <= 3'd0;
            over_count   <= over_count + 5'd1;
          end else begin
            ball_in_over <= ball_in_over + 3'd1;
          end
        end
      end

      if ((state == S_IDLE || state == S_DONE) && seed_ld)
        lfsr <= (seed == 16'd0) ? DEF_SEED : seed;

      // Idle spacing between deliveries: loaded on GAP entry, counts down to zero.
      if (state != S_GAP && state_n == S_GAP) gap_cnt <= GW'(GAP_CYCLES - 1);
      else if (state == S_GAP && gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);
    end
  end

endmodule

// File: tb/tb_delivery_sequencer.sv
// Directed bench for delivery_sequencer: a reference LFSR/outcome model feeds a payload scoreboard,
// and counter, innings, game_over and reset behaviour are compared against the model.
module tb_delivery_sequencer;

  logic        clk = 1'b0;
  logic        rst, play, seed_ld, game_over, del_ready;
  logic [15:0] seed;
  logic        del_valid, del_wicket, del_extra, team, innings_over, match_done;
  logic [2:0]  del_runs, ball_in_over;
  logic [6:0]  legal_balls;
  logic [4:0]  over_count;
  logic [3:0]  wickets;

  typedef struct packed {
    logic [2:0] runs;
    logic       wicket;
    logic       extra;
  } pay_t;

  pay_t        expq[$];
  int          tests = 0;
  int          fails = 0;
  logic [15:0] m_lfsr;
  int          m_legal, m_bio, m_over, m_wk;
  logic        m_end;

  delivery_sequencer dut (
    .clk(clk), .rst(rst), .play(play), .seed_ld(seed_ld), .seed(seed),
    .game_over(game_over), .del_ready(del_ready), .del_valid(del_valid),
    .del_runs(del_runs), .del_wicket(del_wicket), .del_extra(del_extra),
    .team(team), .legal_balls(legal_balls), .over_count(over_count),
    .ball_in_over(ball_in_over), .wickets(wickets),
    .innings_over(innings_over), .match_done(match_done)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic pay_t decode(input logic [3:0] v);
    pay_t p;
    p = '0;
    if (v >= 4'd4 && v <= 4'd7) p.runs = 3'd1;
    else if (v == 4'd8) p.runs = 3'd2;
    else if (v == 4'd9) p.runs = 3'd3;
    else if (v == 4'd10 || v == 4'd11) p.runs = 3'd4;
    else if (v == 4'd12) p.runs = 3'd6;
    else if (v == 4'd13) p.wicket = 1'b1;
    else if (v >= 4'd14) begin
      p.runs  = 3'd1;
      p.extra = 1'b1;
    end
    return p;
  endfunction

  function automatic logic [15:0] step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  task automatic model_clear();
    m_legal = 0; m_bio = 0; m_over = 0; m_wk = 0; m_end = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(del_valid), 32'd0);
    check({tag, "_payload"}, 32'({del_runs, del_wicket, del_extra}), 32'd0);
    check({tag, "_team"}, 32'(team), 32'd0);
    check({tag, "_counters"}, 32'({legal_balls, over_count, ball_in_over, wickets}), 32'd0);
    check({tag, "_flags"}, 32'({innings_over, match_done}), 32'd0);
  endtask

  task automatic wait_valid(output bit ok);
    int w;
    w = 0;
    while (!del_valid && w < 30) begin
      @(negedge clk);
      w++;
    end
    ok = del_valid;
    if (!ok) check("valid_timeout", 32'd0, 32'd1);
  endtask

  // One delivery: predict its payload, hold off ready for 'hold' cycles, accept, then check counters.
  task automatic deliver(input int hold);
    pay_t exp, first, cur;
    bit   ok;
    expq.push_back(decode(m_lfsr[3:0]));
    wait_valid(ok);
    if (!ok) begin
      void'(expq.pop_front());
      return;
    end
    first = {del_runs, del_wicket, del_extra};
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      cur = {del_runs, del_wicket, del_extra};
      check("hold_valid", 32'(del_valid), 32'd1);
      check("hold_payload", 32'(cur), 32'(first));
    end
    exp = expq.pop_front();
    check("payload", 32'({del_runs, del_wicket, del_extra}), 32'(exp));
    del_ready = 1'b1;
    @(negedge clk);
    del_ready = 1'b0;
    m_lfsr = step(m_lfsr);
    if (!exp.extra) begin
      m_legal++;
      if (m_bio == 5) begin
        m_bio = 0;
        m_over++;
      end else begin
        m_bio++;
      end
    end
    if (exp.wicket) m_wk++;
    m_end = (m_legal == 120) || (m_wk == 10);
    if (m_end) play = 1'b0;
    check("legal_balls", 32'(legal_balls), 32'(m_legal));
    check("ball_in_over", 32'(ball_in_over), 32'(m_bio));
    check("over_count", 32'(over_count), 32'(m_over));
    check("wickets", 32'(wickets), 32'(m_wk));
    check("innings_over", 32'(innings_over), 32'(m_end));
    check("valid_after_xfer", 32'(del_valid), 32'd0);
  endtask

  initial begin
    bit   ok;
    int   seen;
    pay_t exp;
    rst = 1'b0; play = 1'b0; seed_ld = 1'b0; seed = 16'd0;
    game_over = 1'b0; del_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");

    // Seed 000D: first delivery is a wicket on a legal ball.
    rst = 1'b1; seed_ld = 1'b1; seed = 16'h000D;
    @(negedge clk);
    seed_ld = 1'b0;
    m_lfsr = 16'h000D; model_clear();
    play = 1'b1;
    deliver(0);
    check("seed_d_wicket", 32'(wickets), 32'd1);

    // Seed 000E: an extra held under backpressure, then a full first innings.
    rst = 1'b0; play = 1'b0;
    @(negedge clk);
    rst = 1'b1; seed_ld = 1'b1; seed = 16'h000E;
    @(negedge clk);
    seed_ld = 1'b0;
    m_lfsr = 16'h000E; model_clear();
    play = 1'b1;
    deliver(5);
    check("seed_e_no_legal", 32'(legal_balls), 32'd0);
    for (int k = 0; k < 400 && !m_end; k++) deliver(k % 3);
    check("innings1_ended", 32'(m_end), 32'd1);

    // BREAK holds counters with play low; innings_over is a single pulse.
    @(negedge clk);
    check("break_pulse_done", 32'(innings_over), 32'd0);
    repeat (3) @(negedge clk);
    check("break_valid", 32'(del_valid), 32'd0);
    check("break_team", 32'(team), 32'd0);
    check("break_legal_held", 32'(legal_balls), 32'(m_legal));
    check("break_wk_held", 32'(wickets), 32'(m_wk));
    play = 1'b1;
    @(negedge clk);
    check("inn2_team", 32'(team), 32'd1);
    check("inn2_counters", 32'({legal_balls, over_count, ball_in_over, wickets}), 32'd0);
    check("inn2_valid", 32'(del_valid), 32'd1);
    model_clear();
    for (int k = 0; k < 3; k++) deliver(1);

    // game_over while a delivery is offered.
    expq.push_back(decode(m_lfsr[3:0]));
    wait_valid(ok);
    exp = expq.pop_front();
    if (ok) check("go_payload", 32'({del_runs, del_wicket, del_extra}), 32'(exp));
    game_over = 1'b1;
    @(negedge clk);
    game_over = 1'b0;
    check("go_valid", 32'(del_valid), 32'd0);
    check("go_done", 32'(match_done), 32'd1);
    del_ready = 1'b1; seed_ld = 1'b1; seed = 16'h1234;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (del_valid) seen++;
    end
    seed_ld = 1'b0; del_ready = 1'b0;
    check("done_no_deliveries", 32'(seen), 32'd0);
    check("done_stays", 32'(match_done), 32'd1);

    // Reset while a delivery is offered and not accepted.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("bowl_before_rst", 32'(del_valid), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("mid_rst");
    rst = 1'b1;
    m_lfsr = 16'hACE1; model_clear();
    for (int k = 0; k < 4; k++) deliver(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
